// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO responder (PHY side).
// MDC and MDIO are oversampled on clk. Frames addressed to PHY_ADDR are decoded and served
// from a 32x16 register file. Reg 2/3 return PHY_ID1/PHY_ID2. Reg 0 bit 15 is a
// self-clearing soft reset.
// Optional build macro MDIO_PRE_SUPPRESS_EN: after a completed frame, the next frame may
// start without a preamble.
module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDR     = 5'b10000,
  parameter int unsigned PRE_LEN      = 32,
  parameter logic [15:0] PHY_ID1      = 16'h0141,
  parameter logic [15:0] PHY_ID2      = 16'h0CC2,
  parameter logic [15:0] REG0_DEFAULT = 16'h1140
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  output logic        wr_stb,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        frame_err
);

  localparam int unsigned CntW = $clog2(PRE_LEN + 1);
  localparam logic [CntW-1:0] PreMax = CntW'(PRE_LEN);

`ifdef MDIO_PRE_SUPPRESS_EN
  // A completed frame counts as a full preamble for the next one.
  localparam logic [CntW-1:0] PreAfterFrame = PreMax;
`else
  localparam logic [CntW-1:0] PreAfterFrame = '0;
`endif

  // Bit 15 of reg 0 is never stored, so it always reads back 0.
  localparam logic [15:0] Reg0Rst = {1'b0, REG0_DEFAULT[14:0]};

  localparam logic [2:0] StPre  = 3'd0;
  localparam logic [2:0] StSt   = 3'd1;
  localparam logic [2:0] StOp   = 3'd2;
  localparam logic [2:0] StPhy  = 3'd3;
  localparam logic [2:0] StReg  = 3'd4;
  localparam logic [2:0] StTa   = 3'd5;
  localparam logic [2:0] StData = 3'd6;

  logic mdc_meta_q, mdc_sync_q, mdc_prev_q;
  logic mdio_meta_q, mdio_sync_q;
  logic rise;
  logic bit_in;

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] pre_cnt_q, pre_cnt_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic            is_read_q, is_read_d;
  logic            first_bit_q, first_bit_d;
  logic [4:0]      phyad_q, phyad_d;
  logic [4:0]      regad_q, regad_d;
  logic [15:0]     shift_q, shift_d;
  logic            mdio_o_q, mdio_o_d;
  logic            mdio_oe_q, mdio_oe_d;
  logic            wr_stb_q, wr_stb_d;
  logic [4:0]      wr_addr_q, wr_addr_d;
  logic [15:0]     wr_data_q, wr_data_d;
  logic            frame_err_q, frame_err_d;

  logic            commit;
  logic            soft_rst;
  logic [15:0]     rd_data;
  logic [15:0]     regs_q [32];

  // Two-flop synchronizers, plus one extra MDC stage for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdc_meta_q  <= 1'b0;
      mdc_sync_q  <= 1'b0;
      mdc_prev_q  <= 1'b0;
      mdio_meta_q <= 1'b1;
      mdio_sync_q <= 1'b1;
    end else begin
      mdc_meta_q  <= mdc;
      mdc_sync_q  <= mdc_meta_q;
      mdc_prev_q  <= mdc_sync_q;
      mdio_meta_q <= mdio_i;
      mdio_sync_q <= mdio_meta_q;
    end
  end

  assign rise   = mdc_sync_q & ~mdc_prev_q;
  assign bit_in = mdio_sync_q;

  // Read mux for the addressed register.
  always_comb begin
    rd_data = regs_q[regad_q];
    if (regad_q == 5'd2) begin
      rd_data = PHY_ID1;
    end else if (regad_q == 5'd3) begin
      rd_data = PHY_ID2;
    end
  end

  // Frame decoder: advances one bit per detected MDC rise.
  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    is_read_d   = is_read_q;
    first_bit_d = first_bit_q;
    phyad_d     = phyad_q;
    regad_d     = regad_q;
    shift_d     = shift_q;
    mdio_o_d    = mdio_o_q;
    mdio_oe_d   = mdio_oe_q;
    wr_stb_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;
    commit      = 1'b0;

    if (rise) begin
      case (state_q)
        StPre: begin
          if (bit_in) begin
            if (pre_cnt_q != PreMax) begin
              pre_cnt_d = pre_cnt_q + 1'b1;
            end
          end else begin
            // This 0 is ST bit 0 only after a full preamble.
            if (pre_cnt_q == PreMax) begin
              state_d = StSt;
            end
            pre_cnt_d = '0;
          end
        end

        StSt: begin
          if (bit_in) begin
            state_d   = StOp;
            bit_cnt_d = '0;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StPre;
          end
        end

        StOp: begin
          if (bit_cnt_q == 4'd0) begin
            first_bit_d = bit_in;
            bit_cnt_d   = 4'd1;
          end else begin
            bit_cnt_d = '0;
            if (first_bit_q && !bit_in) begin
              is_read_d = 1'b1;
              state_d   = StPhy;
            end else if (!first_bit_q && bit_in) begin
              is_read_d = 1'b0;
              state_d   = StPhy;
            end else begin
              state_d = StPre;
            end
          end
        end

        StPhy: begin
          phyad_d = {phyad_q[3:0], bit_in};
          if (bit_cnt_q == 4'd4) begin
            bit_cnt_d = '0;
            state_d   = StReg;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end

        StReg: begin
          regad_d = {regad_q[3:0], bit_in};
          if (bit_cnt_q == 4'd4) begin
            bit_cnt_d = '0;
            // Frames for other PHYs are dropped silently; the line stays released.
            state_d   = (phyad_q == PHY_ADDR) ? StTa : StPre;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end

        StTa: begin
          if (is_read_q) begin
            if (bit_cnt_q == 4'd0) begin
              // Drive the TA zero for slot 2.
              mdio_o_d  = 1'b0;
              mdio_oe_d = 1'b1;
              bit_cnt_d = 4'd1;
            end else begin
              mdio_o_d  = rd_data[15];
              shift_d   = {rd_data[14:0], 1'b0};
              bit_cnt_d = '0;
              state_d   = StData;
            end
          end else begin
            if (bit_cnt_q == 4'd0) begin
              first_bit_d = bit_in;
              bit_cnt_d   = 4'd1;
            end else begin
              bit_cnt_d = '0;
              if (first_bit_q && !bit_in) begin
                state_d = StData;
              end else begin
                frame_err_d = 1'b1;
                state_d     = StPre;
              end
            end
          end
        end

        StData: begin
          if (is_read_q) begin
            if (bit_cnt_q == 4'd15) begin
              mdio_o_d  = 1'b1;
              mdio_oe_d = 1'b0;
              bit_cnt_d = '0;
              pre_cnt_d = PreAfterFrame;
              state_d   = StPre;
            end else begin
              mdio_o_d  = shift_q[15];
              shift_d   = {shift_q[14:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            shift_d = {shift_q[14:0], bit_in};
            if (bit_cnt_q == 4'd15) begin
              commit    = 1'b1;
              wr_stb_d  = 1'b1;
              wr_addr_d = regad_q;
              wr_data_d = {shift_q[14:0], bit_in};
              bit_cnt_d = '0;
              pre_cnt_d = PreAfterFrame;
              state_d   = StPre;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end

        default: begin
          state_d   = StPre;
          pre_cnt_d = '0;
          mdio_o_d  = 1'b1;
          mdio_oe_d = 1'b0;
        end
      endcase
    end
  end

  // Decoder state and registered pad/strobe outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StPre;
      pre_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      is_read_q   <= 1'b0;
      first_bit_q <= 1'b0;
      phyad_q     <= '0;
      regad_q     <= '0;
      shift_q     <= '0;
      mdio_o_q    <= 1'b1;
      mdio_oe_q   <= 1'b0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      is_read_q   <= is_read_d;
      first_bit_q <= first_bit_d;
      phyad_q     <= phyad_d;
      regad_q     <= regad_d;
      shift_q     <= shift_d;
      mdio_o_q    <= mdio_o_d;
      mdio_oe_q   <= mdio_oe_d;
      wr_stb_q    <= wr_stb_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign soft_rst = commit && (wr_addr_d == 5'd0) && wr_data_d[15];

  // Register file; soft reset restores every register in the commit cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= (i == 0) ? Reg0Rst : 16'h0000;
      end
    end else if (soft_rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= (i == 0) ? Reg0Rst : 16'h0000;
      end
    end else if (commit) begin
      if (wr_addr_d == 5'd0) begin
        regs_q[0] <= {1'b0, wr_data_d[14:0]};
      end else if (wr_addr_d != 5'd2 && wr_addr_d != 5'd3) begin
        regs_q[wr_addr_d] <= wr_data_d;
      end
    end
  end

  assign mdio_o    = mdio_o_q;
  assign mdio_oe   = mdio_oe_q;
  assign wr_stb    = wr_stb_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Self-checking bench for mdio_phy_responder: directed frames plus randomized
// write/read-back against a register-map model.
module tb_mdio_phy_responder;

  localparam logic [4:0] Phy = 5'b10000;
`ifdef MDIO_PRE_SUPPRESS_EN
  localparam bit Suppress = 1'b1;
`else
  localparam bit Suppress = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mdc = 1'b0;
  logic        m_en = 1'b0;
  logic        m_bit = 1'b1;
  logic        mdio_line;
  logic        mdio_o, mdio_oe, wr_stb, frame_err;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;

  int vectors = 0;
  int miscompares = 0;

  // Bus: DUT when enabled, else master when enabled, else pull-up.
  assign mdio_line = mdio_oe ? mdio_o : (m_en ? m_bit : 1'b1);

  mdio_phy_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mdc       (mdc),
    .mdio_i    (mdio_line),
    .mdio_o    (mdio_o),
    .mdio_oe   (mdio_oe),
    .wr_stb    (wr_stb),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Event monitors.
  int   stb_pulses = 0, stb_cycles = 0, err_pulses = 0, oe_cycles = 0;
  logic stb_prev = 1'b0, err_prev = 1'b0;
  always @(negedge clk) begin
    if (wr_stb) stb_cycles++;
    if (wr_stb && !stb_prev) stb_pulses++;
    if (frame_err && !err_prev) err_pulses++;
    if (mdio_oe) oe_cycles++;
    stb_prev = wr_stb;
    err_prev = frame_err;
  end

  // Register-map model.
  logic [15:0] model [32];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 16'h0000;
    model[0] = 16'h1140;
  endtask

  task automatic model_write(input logic [4:0] a, input logic [15:0] d);
    if (a == 5'd0 && d[15]) model_reset();
    else if (a == 5'd0) model[0] = d & 16'h7fff;
    else if (a != 5'd2 && a != 5'd3) model[a] = d;
  endtask

  function automatic logic [15:0] model_read(input logic [4:0] a);
    if (a == 5'd2) return 16'h0141;
    if (a == 5'd3) return 16'h0CC2;
    return model[a];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One MDC period: data set while low, line sampled just before the rise.
  logic samp_o, samp_oe;
  task automatic mbit(input logic b, input logic drive);
    m_en  = drive;
    m_bit = b;
    #49;
    samp_o  = mdio_o;
    samp_oe = mdio_oe;
    #1 mdc = 1'b1;
    #50 mdc = 1'b0;
  endtask

  task automatic send(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) mbit(v[i], 1'b1);
  endtask

  task automatic preamble(input int n);
    for (int i = 0; i < n; i++) mbit(1'b1, 1'b1);
  endtask

  task automatic write_frame(input int npre, input logic [4:0] phy, input logic [4:0] ra,
                             input logic [15:0] d, input logic [1:0] ta);
    preamble(npre);
    send(16'b01, 2);
    send(16'b01, 2);
    send({11'd0, phy}, 5);
    send({11'd0, ra}, 5);
    send({14'd0, ta}, 2);
    send(d, 16);
    m_en = 1'b0;
  endtask

  // Read results.
  logic [15:0] r_data;
  logic        r_ta1_oe, r_ta2_oe, r_ta2_o, r_end_oe, r_end_o, r_abort_oe;
  int          r_data_oe;

  task automatic read_frame(input int npre, input logic [4:0] phy, input logic [4:0] ra,
                            input int abort_at);
    r_data = '0; r_data_oe = 0; r_end_oe = 1'bx; r_end_o = 1'bx; r_abort_oe = 1'bx;
    preamble(npre);
    send(16'b01, 2);
    send(16'b10, 2);
    send({11'd0, phy}, 5);
    send({11'd0, ra}, 5);
    mbit(1'b1, 1'b0);
    r_ta1_oe = samp_oe;
    mbit(1'b1, 1'b0);
    r_ta2_oe = samp_oe;
    r_ta2_o  = samp_o;
    for (int k = 0; k < 16; k++) begin
      if (k == abort_at) begin
        r_abort_oe = mdio_oe;
        rst_n = 1'b0;
        return;
      end
      mbit(1'b1, 1'b0);
      r_data[15-k] = samp_o;
      if (samp_oe) r_data_oe++;
    end
    mbit(1'b1, 1'b0);
    r_end_oe = samp_oe;
    r_end_o  = samp_o;
  endtask

  task automatic read_check(input string tag, input logic [4:0] ra);
    read_frame(32, Phy, ra, -1);
    check({tag, "_data"}, {16'd0, r_data}, {16'd0, model_read(ra)});
    check({tag, "_oe"}, r_data_oe, 16);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_stb, s_cyc, s_err, s_oe, npre;
    logic [4:0]  ra, rb;
    logic [15:0] d;

    model_reset();
    #20;
    check("rst_mdio_o", {31'd0, mdio_o}, 1);
    check("rst_mdio_oe", {31'd0, mdio_oe}, 0);
    check("rst_wr_stb", {31'd0, wr_stb}, 0);
    check("rst_wr_addr", {27'd0, wr_addr}, 0);
    check("rst_wr_data", {16'd0, wr_data}, 0);
    check("rst_frame_err", {31'd0, frame_err}, 0);
    #30 rst_n = 1'b1;
    #52;

    // Basic write and read-back.
    s_stb = stb_pulses; s_cyc = stb_cycles;
    write_frame(32, Phy, 5'd16, 16'h0060, 2'b10);
    model_write(5'd16, 16'h0060);
    check("wr1_pulses", stb_pulses - s_stb, 1);
    check("wr1_stb_width", stb_cycles - s_cyc, 1);
    check("wr1_addr", {27'd0, wr_addr}, 16);
    check("wr1_data", {16'd0, wr_data}, 16'h0060);
    read_check("rd16", 5'd16);

    // Read of the PHY ID register, with turnaround timing.
    read_frame(32, Phy, 5'd2, -1);
    check("id_ta1_oe", {31'd0, r_ta1_oe}, 0);
    check("id_ta2_oe", {31'd0, r_ta2_oe}, 1);
    check("id_ta2_o", {31'd0, r_ta2_o}, 0);
    check("id_data", {16'd0, r_data}, 16'h0141);
    check("id_data_oe", r_data_oe, 16);
    check("id_end_oe", {31'd0, r_end_oe}, 0);
    check("id_end_o", {31'd0, r_end_o}, 1);

    // Soft reset via reg 0 bit 15.
    write_frame(32, Phy, 5'd0, 16'h8140, 2'b10);
    model_write(5'd0, 16'h8140);
    read_check("sr_rd16", 5'd16);
    read_check("sr_rd0", 5'd0);

    // Frames for another PHY are ignored; a short preamble is ignored.
    s_stb = stb_pulses; s_oe = oe_cycles;
    read_frame(32, 5'b00001, 5'd16, -1);
    write_frame(32, 5'b00001, 5'd16, 16'h1230, 2'b10);
    check("oth_no_stb", stb_pulses - s_stb, 0);
    check("oth_no_oe", oe_cycles - s_oe, 0);
    write_frame(31, Phy, 5'd16, 16'h7770, 2'b10);
    check("short_pre_no_stb", stb_pulses - s_stb, 0);
    read_check("short_pre_rd", 5'd16);

    // Malformed frames.
    s_stb = stb_pulses; s_err = err_pulses;
    write_frame(32, Phy, 5'd17, 16'h4320, 2'b11);
    check("ta11_err", err_pulses - s_err, 1);
    check("ta11_no_stb", stb_pulses - s_stb, 0);
    s_err = err_pulses;
    preamble(32);
    send(16'b00, 2);
    check("st_err", err_pulses - s_err, 1);
    s_err = err_pulses;
    preamble(32);
    send(16'b0111, 4);
    send(16'h0000, 16);
    check("op11_no_err", err_pulses - s_err, 0);
    check("op11_no_stb", stb_pulses - s_stb, 0);
    read_check("ta11_rd17", 5'd17);

    // Randomized writes (including ID registers) with read-back.
    for (int i = 0; i < 10; i++) begin
      ra = 5'($urandom_range(1, 31));
      d = 16'($urandom);
      npre = 32 + int'($urandom_range(0, 6));
      s_stb = stb_pulses;
      write_frame(npre, Phy, ra, d, 2'b10);
      model_write(ra, d);
      check("rnd_stb", stb_pulses - s_stb, 1);
      check("rnd_addr", {27'd0, wr_addr}, {27'd0, ra});
      check("rnd_data", {16'd0, wr_data}, {16'd0, d});
      rb = ($urandom_range(0, 1) != 0) ? ra : 5'($urandom_range(0, 31));
      read_check("rnd_rd", rb);
    end

    // Back-to-back writes, the second without preamble.
    s_stb = stb_pulses;
    write_frame(32, Phy, 5'd20, 16'h1357, 2'b10);
    model_write(5'd20, 16'h1357);
    write_frame(0, Phy, 5'd21, 16'h2468, 2'b10);
    if (Suppress) model_write(5'd21, 16'h2468);
    check("b2b_commits", stb_pulses - s_stb, Suppress ? 2 : 1);
    read_check("b2b_rd21", 5'd21);

    // Reset asserted during read data.
    write_frame(32, Phy, 5'd16, 16'hBEEF, 2'b10);
    model_write(5'd16, 16'hBEEF);
    read_frame(32, Phy, 5'd16, 5);
    #1;
    check("abort_was_driving", {31'd0, r_abort_oe}, 1);
    check("abort_oe", {31'd0, mdio_oe}, 0);
    check("abort_o", {31'd0, mdio_o}, 1);
    model_reset();
    #49 rst_n = 1'b1;
    #50;
    read_check("abort_rd16", 5'd16);
    read_check("abort_rd0", 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
